// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: widths, functional-unit indices, slot states and
// the funct7-to-unit decode used in front of the issuer.
package fpu_pkg;

   localparam int WORD   = 32;
   localparam int UNIT_W = 4;

   localparam logic [UNIT_W-1:0] UNIT_FADD   = 4'd0;
   localparam logic [UNIT_W-1:0] UNIT_FSUB   = 4'd1;
   localparam logic [UNIT_W-1:0] UNIT_FMUL   = 4'd2;
   localparam logic [UNIT_W-1:0] UNIT_FDIV   = 4'd3;
   localparam logic [UNIT_W-1:0] UNIT_FSQRT  = 4'd4;
   localparam logic [UNIT_W-1:0] UNIT_FSGNJ  = 4'd5;
   localparam logic [UNIT_W-1:0] UNIT_FFLOOR = 4'd6;
   localparam logic [UNIT_W-1:0] UNIT_ITOF   = 4'd7;
   localparam logic [UNIT_W-1:0] UNIT_FTOI   = 4'd8;
   localparam logic [UNIT_W-1:0] UNIT_FMVI   = 4'd9;
   localparam logic [UNIT_W-1:0] UNIT_IMVF   = 4'd10;
   localparam logic [UNIT_W-1:0] UNIT_FCOMP  = 4'd11;
   localparam logic [UNIT_W-1:0] UNIT_NONE   = 4'd15;

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_ORDER = 2'd1,
      SLOT_WAIT  = 2'd2
   } slot_state_t;

   // Unknown encodings map to UNIT_NONE so the op completes with an error flag.
   function automatic logic [UNIT_W-1:0] unit_from_funct7(input logic [6:0] funct7);
      logic [UNIT_W-1:0] unit;
      unit = UNIT_NONE;
      case (funct7)
         7'b0000000: unit = UNIT_FADD;
         7'b0000100: unit = UNIT_FSUB;
         7'b0001000: unit = UNIT_FMUL;
         7'b0001100: unit = UNIT_FDIV;
         7'b0101100: unit = UNIT_FSQRT;
         7'b0010000: unit = UNIT_FSGNJ;
         7'b0010100: unit = UNIT_FFLOOR;
         7'b1101000: unit = UNIT_ITOF;
         7'b1100000: unit = UNIT_FTOI;
         7'b1110000: unit = UNIT_FMVI;
         7'b1111000: unit = UNIT_IMVF;
         7'b1010000: unit = UNIT_FCOMP;
         default:    unit = UNIT_NONE;
      endcase
      return unit;
   endfunction

endpackage

// File: rtl/fpu_unit_slot.sv
// One functional-unit slot: IDLE/ORDER/WAIT handshake FSM plus the operands and
// reorder-buffer index captured when an op is allocated to the unit.
module fpu_unit_slot #(
   parameter int WORD  = 32,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc,
   input  logic [2:0]       alloc_func3,
   input  logic [WORD-1:0]  alloc_rs1,
   input  logic [WORD-1:0]  alloc_rs2,
   input  logic [IDX_W-1:0] alloc_idx,
   input  logic             accepted,
   input  logic             done,
   output logic             order,
   output logic             idle,
   output logic [2:0]       func3,
   output logic [WORD-1:0]  rs1,
   output logic [WORD-1:0]  rs2,
   output logic [IDX_W-1:0] idx
);
   import fpu_pkg::*;

   slot_state_t state_reg, state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= SLOT_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A finishing unit may be handed its next op in the same cycle.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         SLOT_IDLE:  if (alloc) state_next = SLOT_ORDER;
         SLOT_ORDER: begin
            if (done)          state_next = SLOT_IDLE;
            else if (accepted) state_next = SLOT_WAIT;
         end
         SLOT_WAIT:  if (done) state_next = SLOT_IDLE;
         default:    state_next = SLOT_IDLE;
      endcase
      if (alloc) state_next = SLOT_ORDER;
   end

   assign order = (state_reg == SLOT_ORDER);
   assign idle  = (state_reg == SLOT_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         func3 <= '0;
         rs1   <= '0;
         rs2   <= '0;
         idx   <= '0;
      end else if (alloc) begin
         func3 <= alloc_func3;
         rs1   <= alloc_rs1;
         rs2   <= alloc_rs2;
         idx   <= alloc_idx;
      end
   end

endmodule

// File: rtl/fpu_issue_rob.sv
// Multi-unit FP issuer: dispatches ops to per-unit slots and returns results
// strictly in issue order through a small reorder buffer.
module fpu_issue_rob #(
   parameter int WORD      = fpu_pkg::WORD,
   parameter int NUM_UNITS = 12,
   parameter int UNIT_W    = fpu_pkg::UNIT_W,
   parameter int DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [UNIT_W-1:0]         in_unit,
   input  logic [2:0]                in_func3,
   input  logic [WORD-1:0]           in_rs1,
   input  logic [WORD-1:0]           in_rs2,
   output logic [NUM_UNITS-1:0]      u_order,
   input  logic [NUM_UNITS-1:0]      u_accepted,
   input  logic [NUM_UNITS-1:0]      u_done,
   output logic [3*NUM_UNITS-1:0]    u_func3,
   output logic [WORD*NUM_UNITS-1:0] u_rs1,
   output logic [WORD*NUM_UNITS-1:0] u_rs2,
   input  logic [WORD*NUM_UNITS-1:0] u_rd,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WORD-1:0]           out_rd,
   output logic                      out_err,
   output logic                      busy,
   output logic                      proto_err
);
   import fpu_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NSEL  = 1 << UNIT_W;
   localparam logic [UNIT_W:0] NUM_UNITS_L = (UNIT_W + 1)'(NUM_UNITS);
   localparam logic [CNT_W-1:0] DEPTH_L    = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg;
   logic             proto_err_reg;
   logic             rob_cmp_reg [DEPTH];
   logic             rob_err_reg [DEPTH];
   logic [WORD-1:0]  rob_rd_reg  [DEPTH];

   logic [NUM_UNITS-1:0] slot_idle, slot_order, cap_done;
   logic [PTR_W-1:0]     slot_idx [NUM_UNITS];
   logic [NSEL-1:0]      idle_sel, done_sel;
   logic                 unit_ok, accept, pop;

   // Widen per-unit status to the full select range so any in_unit is a legal index.
   always_comb begin
      idle_sel = '0;
      done_sel = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         idle_sel[i] = slot_idle[i];
         done_sel[i] = u_done[i];
      end
   end

   assign unit_ok  = ({1'b0, in_unit} < NUM_UNITS_L);
   assign in_ready = (count_reg < DEPTH_L) &
                     (~unit_ok | idle_sel[in_unit] | done_sel[in_unit]);
   assign accept   = in_valid & in_ready;
   assign out_valid = rob_cmp_reg[head_reg];
   assign out_rd    = rob_rd_reg[head_reg];
   assign out_err   = rob_err_reg[head_reg];
   assign pop       = out_valid & out_ready;
   assign busy      = (count_reg != '0);
   assign proto_err = proto_err_reg;
   assign cap_done  = u_done & ~slot_idle;
   assign u_order   = slot_order;

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
         logic alloc;
         assign alloc = accept & unit_ok & (in_unit == UNIT_W'(gi));

         fpu_unit_slot #(
            .WORD  (WORD),
            .IDX_W (PTR_W)
         ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .alloc       (alloc),
            .alloc_func3 (in_func3),
            .alloc_rs1   (in_rs1),
            .alloc_rs2   (in_rs2),
            .alloc_idx   (tail_reg),
            .accepted    (u_accepted[gi]),
            .done        (u_done[gi]),
            .order       (slot_order[gi]),
            .idle        (slot_idle[gi]),
            .func3       (u_func3[3*gi +: 3]),
            .rs1         (u_rs1[WORD*gi +: WORD]),
            .rs2         (u_rs2[WORD*gi +: WORD]),
            .idx         (slot_idx[gi])
         );
      end
   endgenerate

   // Tail is never an in-flight entry and a complete head has no busy slot,
   // so accept, unit completions and pop never target the same entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         proto_err_reg <= 1'b0;
         for (int d = 0; d < DEPTH; d++) begin
            rob_cmp_reg[d] <= 1'b0;
            rob_err_reg[d] <= 1'b0;
            rob_rd_reg[d]  <= '0;
         end
      end else begin
         if (pop) begin
            rob_cmp_reg[head_reg] <= 1'b0;
            head_reg              <= head_reg + 1'b1;
         end
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (cap_done[i]) begin
               rob_cmp_reg[slot_idx[i]] <= 1'b1;
               rob_err_reg[slot_idx[i]] <= 1'b0;
               rob_rd_reg[slot_idx[i]]  <= u_rd[i*WORD +: WORD];
            end
         end
         if (accept) begin
            rob_cmp_reg[tail_reg] <= ~unit_ok;
            rob_err_reg[tail_reg] <= ~unit_ok;
            rob_rd_reg[tail_reg]  <= '0;
            tail_reg              <= tail_reg + 1'b1;
         end
         if (accept && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (!accept && pop) begin
            count_reg <= count_reg - 1'b1;
         end
         if ((u_done & slot_idle) != '0) begin
            proto_err_reg <= 1'b1;
         end
      end
   end

endmodule
